// File: rtl/pipelined_adder.sv
// WIDTH-bit add/subtract split into STAGES registered carry segments, with a
// valid/ready handshake on both sides and one result retired per cycle.
module pipelined_adder #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);
    localparam int CW = WIDTH / STAGES;

    if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
        $error("pipelined_adder: illegal WIDTH/STAGES combination");
    end

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;

    // Subtraction is folded into an ordinary addition of the inverted operand.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign b_eff    = in_sub ? ~in_b : in_b;
    assign c_eff    = in_sub ? ~in_cin : in_cin;

    genvar gi;
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
        // Stage gi sees only the operand bits not yet summed, and emits a
        // partial sum that grows by one segment per stage.
        localparam int UW = WIDTH - gi * CW;
        localparam int SW = (gi + 1) * CW;

        logic [UW-1:0] a_in;
        logic [UW-1:0] b_in;
        logic          c_in;
        logic          v_in;
        logic [CW:0]   seg;
        logic [SW-1:0] sum_next;
        logic          valid_reg;
        logic          carry_reg;
        logic [SW-1:0] sum_reg;

        if (gi == 0) begin : g_head
            assign a_in     = in_a;
            assign b_in     = b_eff;
            assign c_in     = c_eff;
            assign v_in     = in_valid;
            assign sum_next = seg[CW-1:0];
        end else begin : g_body
            assign a_in     = g_stage[gi-1].g_pass.a_reg;
            assign b_in     = g_stage[gi-1].g_pass.b_reg;
            assign c_in     = g_stage[gi-1].carry_reg;
            assign v_in     = g_stage[gi-1].valid_reg;
            assign sum_next = {seg[CW-1:0], g_stage[gi-1].sum_reg};
        end

        assign seg = {1'b0, a_in[CW-1:0]} + {1'b0, b_in[CW-1:0]} + (CW+1)'(c_in);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_reg <= 1'b0;
            end else if (adv) begin
                valid_reg <= v_in;
            end
        end

        // Data only moves with a real beat, so bubbles leave the outputs untouched.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sum_reg   <= '0;
                carry_reg <= 1'b0;
            end else if (adv && v_in) begin
                sum_reg   <= sum_next;
                carry_reg <= seg[CW];
            end
        end

        if (gi < STAGES - 1) begin : g_pass
            logic [UW-CW-1:0] a_reg;
            logic [UW-CW-1:0] b_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_reg <= '0;
                    b_reg <= '0;
                end else if (adv && v_in) begin
                    a_reg <= a_in[UW-1:CW];
                    b_reg <= b_in[UW-1:CW];
                end
            end
        end else begin : g_tail
            logic ovf_reg;

            // Same-sign operands giving an opposite-sign sum: carry-in to MSB differs from carry-out.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_reg <= 1'b0;
                end else if (adv && v_in) begin
                    ovf_reg <= (a_in[CW-1] == b_in[CW-1]) && (seg[CW-1] != a_in[CW-1]);
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].valid_reg;
    assign out_sum   = g_stage[STAGES-1].sum_reg;
    assign out_cout  = g_stage[STAGES-1].carry_reg;
    assign out_ovf   = g_stage[STAGES-1].g_tail.ovf_reg;

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: three instances (STAGES 2, 1, 8) share stimulus;
// directed cases plus a randomized run against an arithmetic reference model.
module tb_pipelined_adder;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       in_cin;
    logic       in_sub;
    logic       out_ready;
    logic [2:0] in_ready;
    logic [2:0] out_valid;
    logic [2:0] out_cout;
    logic [2:0] out_ovf;
    logic [7:0] out_sum [3];

    int checks = 0;
    int errors = 0;
    int lat_exp [3] = '{2, 1, 8};

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(8), .STAGES(2)) u_s2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(out_valid[0]), .out_ready(out_ready), .out_sum(out_sum[0]),
        .out_cout(out_cout[0]), .out_ovf(out_ovf[0])
    );

    pipelined_adder #(.WIDTH(8), .STAGES(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(out_valid[1]), .out_ready(out_ready), .out_sum(out_sum[1]),
        .out_cout(out_cout[1]), .out_ovf(out_ovf[1])
    );

    pipelined_adder #(.WIDTH(8), .STAGES(8)) u_s8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[2]),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(out_valid[2]), .out_ready(out_ready), .out_sum(out_sum[2]),
        .out_cout(out_cout[2]), .out_ovf(out_ovf[2])
    );

    // Reference: {ovf, cout, sum} from integer arithmetic on the operand values.
    function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b,
                                         input logic cin, input logic sub);
        int ua, ub, sa, sb, full, r;
        logic [7:0] s;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (!sub) begin
            full = ua + ub + int'(cin);
            r    = sa + sb + int'(cin);
            s    = 8'(full);
        end else begin
            full = ua + (255 - ub) + (1 - int'(cin));
            r    = sa - sb - int'(cin);
            s    = 8'(ua - ub - int'(cin));
        end
        return {(r > 127 || r < -128), (full > 255), s};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // One isolated beat; checks latency and result on every instance.
    task automatic op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                      input logic sub, input string tag);
        logic [9:0] e;
        bit seen [3];
        e = model(a, b, cin, sub);
        seen = '{0, 0, 0};
        @(negedge clk);
        in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin; in_sub = sub;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            for (int k = 0; k < 3; k++) begin
                if (!seen[k] && out_valid[k]) begin
                    seen[k] = 1'b1;
                    check($sformatf("%s latency s%0d", tag, lat_exp[k]), n, lat_exp[k]);
                    check($sformatf("%s result s%0d", tag, lat_exp[k]),
                          {22'd0, out_ovf[k], out_cout[k], out_sum[k]}, {22'd0, e});
                end
            end
            if (seen[0] && seen[1] && seen[2]) break;
            @(negedge clk);
        end
        for (int k = 0; k < 3; k++)
            if (!seen[k]) check($sformatf("%s timeout s%0d", tag, lat_exp[k]), 0, 1);
    endtask

    initial begin
        int i, j, stall, first_ret, last_ret;
        bit started;
        logic [7:0] exp_bp [4];
        logic [9:0] q [3][$];
        int accepted [3];
        logic [9:0] e;

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("reset out_valid", out_valid[k], 0);
            check("reset in_ready", in_ready[k], 1);
            check("reset out_sum", out_sum[k], 0);
            check("reset out_cout", out_cout[k], 0);
            check("reset out_ovf", out_ovf[k], 0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        op(8'hFF, 8'h01, 1'b0, 1'b0, "add wrap");
        op(8'h7F, 8'h01, 1'b0, 1'b0, "ovf pos");
        op(8'h80, 8'hFF, 1'b0, 1'b0, "ovf neg");
        op(8'h05, 8'h07, 1'b0, 1'b1, "sub borrow");
        op(8'h05, 8'h07, 1'b1, 1'b1, "sub borrow cin");
        op(8'h7F, 8'hFF, 1'b1, 1'b1, "sub ovf");

        // Backpressure: four back-to-back beats, 3-cycle stall at first result.
        exp_bp = '{8'h11, 8'h22, 8'h33, 8'h44};
        i = 0; j = 0; stall = 0; started = 1'b0; first_ret = -1; last_ret = -1;
        for (int cyc = 0; cyc < 40 && j < 4; cyc++) begin
            @(negedge clk);
            if (out_valid[0] && !started) begin
                started = 1'b1;
                stall = 3;
            end
            out_ready = (stall == 0);
            in_valid = (i < 4);
            in_a = 8'((i + 1) * 16); in_b = 8'(i + 1); in_cin = 1'b0; in_sub = 1'b0;
            #1;
            if (stall > 0) begin
                check("bp in_ready low", in_ready[0], 0);
                check("bp out_valid held", out_valid[0], 1);
                check("bp out_sum held", out_sum[0], 8'h11);
                stall--;
            end
            if (out_valid[0] && out_ready) begin
                check($sformatf("bp result %0d", j), out_sum[0], exp_bp[j]);
                if (j == 0) first_ret = cyc;
                last_ret = cyc;
                j++;
            end
            if (in_valid && in_ready[0]) i++;
        end
        check("bp results retired", j, 4);
        check("bp back-to-back", last_ret - first_ret, 3);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (12) @(negedge clk);

        // Reset with two beats in flight.
        in_valid = 1'b1; in_a = 8'h11; in_b = 8'h22;
        @(posedge clk);
        @(negedge clk);
        in_a = 8'h33; in_b = 8'h44;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("async reset out_valid", out_valid, 3'b000);
        check("async reset out_sum", out_sum[0], 0);
        check("reset in_ready", in_ready, 3'b111);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            check("no stale result", out_valid, 3'b000);
        end
        op(8'h01, 8'h01, 1'b0, 1'b0, "after reset");

        // Randomized run with per-instance scoreboards, then a drain.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        accepted = '{0, 0, 0};
        for (int cyc = 0; cyc < 2060; cyc++) begin
            @(negedge clk);
            if (cyc < 2000) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            in_a = 8'($urandom); in_b = 8'($urandom);
            in_cin = 1'($urandom); in_sub = 1'($urandom);
            #1;
            for (int k = 0; k < 3; k++) begin
                if (out_valid[k] && out_ready) begin
                    check($sformatf("rand expected beat s%0d", lat_exp[k]), q[k].size() != 0, 1);
                    if (q[k].size() != 0) begin
                        e = q[k].pop_front();
                        check($sformatf("rand result s%0d", lat_exp[k]),
                              {22'd0, out_ovf[k], out_cout[k], out_sum[k]}, {22'd0, e});
                    end
                end
                if (in_valid && in_ready[k]) begin
                    q[k].push_back(model(in_a, in_b, in_cin, in_sub));
                    accepted[k]++;
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rand nothing lost s%0d", lat_exp[k]), q[k].size(), 0);
            check($sformatf("rand beats accepted s%0d", lat_exp[k]), accepted[k] > 500, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
